display_control_fsm: RTL and testbench

//   Control stage driving the note-lane display datapath. Clears the 240x120 play region at

---
 rtl/display_control_fsm_pkg.sv | 10 +
 rtl/display_control_fsm_xy_sweep_counter.sv | 28 ++
 rtl/display_control_fsm.sv | 107 ++++++++++
 tb/tb_display_control_fsm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/display_control_fsm_pkg.sv
// display_control_fsm_pkg: state encoding, pixel field widths and strobe pipeline depths
package display_control_fsm_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int CLEAR_LAT = 2;
  localparam int DRAW_LAT = 3;
  typedef enum logic [3:0] {
    IDLE, CLEAR, CLEAR_DRAIN, WAIT_BEAT, SHIFT, BOX_SETTLE, BOX_DRAW, BOX_DRAIN, DONE
  } state_t;
endpackage

// File: rtl/display_control_fsm_xy_sweep_counter.sv
// xy_sweep_counter: raster sweep over a W x H region, y inner and x outer, wrapping to 0 after the last pixel
module xy_sweep_counter
  import display_control_fsm_pkg::*;
#(
  parameter int W = 240,
  parameter int H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);
  assign last = (x == X_LAST) && (y == Y_LAST);
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      y <= (y == Y_LAST) ? '0 : y + 1'b1;
      if (y == Y_LAST) x <= last ? '0 : x + 1'b1;
    end
  end
endmodule

// File: rtl/display_control_fsm.sv
// display_control_fsm: sequences screen clear, beat pacing, note shift and per-beat box redraws,
// with plot delayed to line up with the datapath output registers.
module display_control_fsm
  import display_control_fsm_pkg::*;
#(
  parameter int GRID_W      = 240,
  parameter int GRID_H      = 120,
  parameter int BOX_W       = 16,
  parameter int BOX_H       = 60,
  parameter int NUM_BOXES   = 3,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_BEATS  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        shiftSong,
  output logic        loadStartAddress,
  output logic        loadX,
  output logic        loadY,
  output logic        writeToScreen,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [1:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic        plot,
  output logic        busy
);
  localparam int TW = $clog2(BEAT_CYCLES + 1);
  localparam int BW = $clog2(SONG_BEATS + 1);
  state_t state, nextState;
  logic [TW-1:0] beatTimer;
  logic [BW-1:0] beatCount;
  logic [1:0] drainCount;
  logic [CLEAR_LAT-1:0] clearPipe;
  logic [DRAW_LAT-1:0] drawPipe;
  logic [X_W-1:0] gridX, boxX;
  logic [Y_W-1:0] gridY, boxY;
  logic gridLast, boxLast, beatLast, drainLast, lastBox;

  xy_sweep_counter #(.W(GRID_W), .H(GRID_H)) gridSweep (
    .clock(clock), .reset(reset), .en(state == CLEAR), .clr(state == IDLE),
    .x(gridX), .y(gridY), .last(gridLast)
  );

  xy_sweep_counter #(.W(BOX_W), .H(BOX_H)) boxSweep (
    .clock(clock), .reset(reset), .en(state == BOX_DRAW), .clr(state == BOX_SETTLE),
    .x(boxX), .y(boxY), .last(boxLast)
  );

  assign beatLast  = beatTimer == TW'(BEAT_CYCLES - 1);
  assign lastBox   = boxCounter == 2'(NUM_BOXES - 1);
  assign drainLast = drainCount == ((state == CLEAR_DRAIN) ? 2'(CLEAR_LAT - 1) : 2'(DRAW_LAT - 1));

  // Drain lengths equal the pipeline depths so no strobe outlives its state window.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      beatTimer  <= '0;
      beatCount  <= '0;
      drainCount <= '0;
      boxCounter <= '0;
      clearPipe  <= '0;
      drawPipe   <= '0;
    end else begin
      state      <= nextState;
      beatTimer  <= (state == WAIT_BEAT) ? beatTimer + 1'b1 : '0;
      beatCount  <= (state == CLEAR_DRAIN) ? '0 : beatCount + BW'(state == SHIFT);
      drainCount <= ((state inside {CLEAR_DRAIN, BOX_DRAIN}) && !drainLast) ? drainCount + 1'b1 : '0;
      if ((state == WAIT_BEAT && beatLast) || state == DONE) boxCounter <= '0;
      else if (state == BOX_DRAIN && drainLast && !lastBox) boxCounter <= boxCounter + 1'b1;
      clearPipe  <= {clearPipe[CLEAR_LAT-2:0], state == CLEAR};
      drawPipe   <= {drawPipe[DRAW_LAT-2:0], state == BOX_DRAW};
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:        nextState = start ? CLEAR : IDLE;
      CLEAR:       nextState = gridLast ? CLEAR_DRAIN : CLEAR;
      CLEAR_DRAIN: nextState = drainLast ? WAIT_BEAT : CLEAR_DRAIN;
      WAIT_BEAT:   nextState = beatLast ? SHIFT : WAIT_BEAT;
      SHIFT:       nextState = BOX_SETTLE;
      BOX_SETTLE:  nextState = BOX_DRAW;
      BOX_DRAW:    nextState = boxLast ? BOX_DRAIN : BOX_DRAW;
      BOX_DRAIN:   nextState = !drainLast ? BOX_DRAIN : !lastBox ? BOX_SETTLE :
                               (beatCount == BW'(SONG_BEATS)) ? DONE : WAIT_BEAT;
      DONE:        nextState = IDLE;
      default:     nextState = IDLE;
    endcase
    shiftSong        = state == SHIFT;
    loadStartAddress = state == BOX_SETTLE;
    loadDefault      = state == CLEAR;
    songDone         = state == DONE;
    busy             = state != IDLE;
    loadX            = drawPipe[0];
    loadY            = drawPipe[0];
    writeToScreen    = drawPipe[1];
    writeDefault     = clearPipe[0];
    plot             = clearPipe[CLEAR_LAT-1] | drawPipe[DRAW_LAT-1];
    gridCounter      = {1'b0, gridX, gridY};
    pixelCount       = {boxX, boxY};
  end
endmodule

// File: tb/tb_display_control_fsm.sv
// tb_display_control_fsm: scoreboard bench for the display controller with a 4x3 grid, 2x2 boxes, 5-cycle beats, 2-beat songs
module tb_display_control_fsm;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic shiftSong, loadStartAddress, loadX, loadY, writeToScreen, loadDefault, writeDefault, songDone, plot, busy;
  logic [15:0] gridCounter;
  logic [1:0] boxCounter;
  logic [14:0] pixelCount;
  int nTests = 0, nFail = 0, cyc = 0;
  int nLd = 0, nWd = 0, nLx = 0, nWts = 0, nPlot = 0, nShift = 0, nDone = 0;
  int lastClr = -100, lastDraw = -100, prevPix = 0, prevBox = 0, prevShift = 0;
  int clrQ[$], pixQ[$], boxQ[$], wdQ[$], wtsQ[$], plotCycQ[$], plotBoxQ[$];

  always #5 clock = ~clock;

  display_control_fsm #(
    .GRID_W(4), .GRID_H(3), .BOX_W(2), .BOX_H(2), .NUM_BOXES(3), .BEAT_CYCLES(5), .SONG_BEATS(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .shiftSong(shiftSong),
    .loadStartAddress(loadStartAddress), .loadX(loadX), .loadY(loadY),
    .writeToScreen(writeToScreen), .loadDefault(loadDefault), .writeDefault(writeDefault),
    .songDone(songDone), .gridCounter(gridCounter), .boxCounter(boxCounter),
    .pixelCount(pixelCount), .plot(plot), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fillSong();
    for (int x = 0; x < 4; x++) for (int y = 0; y < 3; y++) clrQ.push_back(x * 128 + y);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 3; k++) begin
        boxQ.push_back(k);
        for (int x = 0; x < 2; x++) for (int y = 0; y < 2; y++) pixQ.push_back(k * 65536 + x * 128 + y);
      end
  endtask

  // Observe one cycle: pixel issues push their expected downstream strobes, strobes pop and compare.
  task automatic sample();
    int b;
    if (loadDefault) begin
      nLd++;
      if (clrQ.size() == 0) check("extraLoadDefault", 1, 0);
      else check("gridCounter", gridCounter, clrQ.pop_front());
      wdQ.push_back(cyc + 1);
      plotCycQ.push_back(cyc + 2);
      plotBoxQ.push_back(-1);
      lastClr = cyc;
    end
    if (writeDefault) begin
      nWd++;
      if (wdQ.size() == 0) check("extraWriteDefault", 1, 0);
      else check("writeDefaultCycle", cyc, wdQ.pop_front());
    end
    if (loadX) begin
      nLx++;
      check("loadY", loadY, 1);
      if (pixQ.size() == 0) check("extraPixel", 1, 0);
      else check("boxPixel", prevBox * 65536 + prevPix, pixQ.pop_front());
      wtsQ.push_back(cyc + 1);
      plotCycQ.push_back(cyc + 2);
      plotBoxQ.push_back(prevBox);
      lastDraw = cyc - 1;
    end
    if (writeToScreen) begin
      nWts++;
      check("writeOverlap", writeDefault, 0);
      if (wtsQ.size() == 0) check("extraWriteToScreen", 1, 0);
      else check("writeToScreenCycle", cyc, wtsQ.pop_front());
    end
    if (plot) begin
      nPlot++;
      if (plotCycQ.size() == 0) check("extraPlot", 1, 0);
      else begin
        check("plotCycle", cyc, plotCycQ.pop_front());
        b = plotBoxQ.pop_front();
        if (b >= 0) check("plotBox", boxCounter, b);
      end
    end
    if (shiftSong) begin
      nShift++;
      check("shiftWidth", prevShift, 0);
      check("shiftCycle", cyc, (lastClr > lastDraw) ? lastClr + 8 : lastDraw + 9);
    end
    if (loadStartAddress) begin
      check("settlePixel", pixelCount, 0);
      if (boxQ.size() == 0) check("extraSettle", 1, 0);
      else check("settleBox", boxCounter, boxQ.pop_front());
    end
    if (songDone) begin
      nDone++;
      check("songDoneCycle", cyc, lastDraw + 4);
      check("pixelsLeft", pixQ.size(), 0);
    end
    prevShift = int'(shiftSong);
    prevPix = int'(pixelCount);
    prevBox = int'(boxCounter);
    cyc++;
  endtask

  task automatic step();
    @(negedge clock);
    sample();
  endtask

  task automatic waitLx(input int n);
    for (int i = 0; i < 400 && nLx < n; i++) step();
    check("loadXReached", int'(nLx >= n), 1);
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, "Strobes"}, {shiftSong, loadStartAddress, loadX, loadY, writeToScreen,
                            loadDefault, writeDefault, songDone, plot, busy}, 0);
    check({tag, "Grid"}, gridCounter, 0);
    check({tag, "Box"}, boxCounter, 0);
    check({tag, "Pixel"}, pixelCount, 0);
  endtask

  initial begin
    repeat (3) step();
    checkQuiet("reset");
    reset = 1'b0;
    step();
    fillSong();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busyAfterStart", busy, 1);
    waitLx(12);
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && nDone < 1; i++) step();
    check("songDoneSeen", nDone, 1);
    step();
    check("busyAfterDone", busy, 0);
    check("songDoneWidth", songDone, 0);
    check("loadDefaultCount", nLd, 12);
    check("writeDefaultCount", nWd, 12);
    check("loadXCount", nLx, 24);
    check("writeToScreenCount", nWts, 24);
    check("plotCount", nPlot, 36);
    check("shiftCount", nShift, 2);
    check("plotsPending", plotCycQ.size(), 0);
    fillSong();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restartBusy", busy, 1);
    waitLx(26);
    reset = 1'b1;
    step();
    checkQuiet("midReset");
    clrQ.delete(); pixQ.delete(); boxQ.delete(); wdQ.delete();
    wtsQ.delete(); plotCycQ.delete(); plotBoxQ.delete();
    reset = 1'b0;
    repeat (6) begin
      step();
      check("noTrailingPlot", plot, 0);
      check("idleAfterReset", busy, 0);
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
